// File: rtl/bus_memory_responder.sv
// Main-memory responder on the snoopy bus: fixed-latency word read/write with a
// level completion handshake, deferring reads to cache-to-cache intervention.
module bus_memory_responder #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned READ_LATENCY  = 3,
  parameter int unsigned WRITE_LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    dataOut,
  input  logic                     readEnabled,
  input  logic                     writeEnabled,
  input  logic                     interventionHit,
  output logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     functionComplete,
  output logic                     busy,
  output logic                     protocolError,
  output logic [15:0]              readCount,
  output logic [15:0]              writeCount
);

  localparam int unsigned DEPTH   = 2 ** ADDRESS_WIDTH;
  localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam int unsigned COUNT_W = 16;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] READ_WAIT  = 3'd1;
  localparam logic [2:0] WRITE_WAIT = 3'd2;
  localparam logic [2:0] COMPLETE   = 3'd3;
  localparam logic [2:0] INTERVENED = 3'd4;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     fc_q, fc_d;
  logic                     perr_q, perr_d;
  logic [COUNT_W-1:0]       read_count_q, read_count_d;
  logic [COUNT_W-1:0]       write_count_q, write_count_d;
  logic                     mem_we_c;

  // Next-state and datapath decisions
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    fc_d          = fc_q;
    perr_d        = perr_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    mem_we_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (readEnabled && writeEnabled) begin
          perr_d = 1'b1;
        end else if (readEnabled) begin
          if (interventionHit) begin
            state_d = INTERVENED;
          end else begin
            addr_d  = address;
            cnt_d   = CNT_W'(READ_LATENCY - 1);
            state_d = READ_WAIT;
          end
        end else if (writeEnabled) begin
          addr_d  = address;
          wdata_d = dataOut;
          cnt_d   = CNT_W'(WRITE_LATENCY - 1);
          state_d = WRITE_WAIT;
        end
      end

      READ_WAIT: begin
        if (!readEnabled) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rdata_d      = mem[addr_q];
          fc_d         = 1'b1;
          read_count_d = read_count_q + COUNT_W'(1);
          state_d      = COMPLETE;
        end
      end

      WRITE_WAIT: begin
        if (!writeEnabled) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          mem_we_c      = 1'b1;
          fc_d          = 1'b1;
          write_count_d = write_count_q + COUNT_W'(1);
          state_d       = COMPLETE;
        end
      end

      COMPLETE: begin
        if (!readEnabled && !writeEnabled) begin
          fc_d    = 1'b0;
          rdata_d = '0;
          state_d = IDLE;
        end
      end

      INTERVENED: begin
        if (!readEnabled) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      fc_q          <= 1'b0;
      perr_q        <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      fc_q          <= fc_d;
      perr_q        <= perr_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
    end
  end

  // Array contents survive reset; a write pending at reset is dropped
  always_ff @(posedge clock) begin
    if (mem_we_c && !reset) mem[addr_q] <= wdata_q;
  end

  assign dataIn           = rdata_q;
  assign functionComplete = fc_q;
  assign busy             = (state_q != IDLE);
  assign protocolError    = perr_q;
  assign readCount        = read_count_q;
  assign writeCount       = write_count_q;

endmodule
